// File: rtl/mult_share_arbiter_pkg.sv
// Shared fixed-point constants and the Q15 product slice for the shared multiplier.
package mult_share_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int Q_FRAC = 15;

  // Q15 x Q15 -> Q15 by truncation: sign bit kept, redundant P[30] dropped.
  function automatic logic signed [DATA_W-1:0] fx_slice(input logic signed [PROD_W-1:0] p);
    return {p[PROD_W-1], p[PROD_W-3:Q_FRAC]};
  endfunction

endpackage

// File: rtl/mult_16_basic.sv
// Plain 16x16 signed multiplier, full-width 32-bit product, purely combinational.
module mult_16_basic
  import mult_share_arbiter_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [PROD_W-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one signed Q15 multiplier between N_REQ requesters,
// with a fixed two-stage result pipeline tagged by requester index.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic signed [DATA_W-1:0]  rsp_q,
  output logic                      busy
);

  logic [IDW-1:0]           ptr;
  logic [IDW-1:0]           ptr_next;
  logic [N_REQ-1:0]         grant;
  logic [IDW-1:0]           gid;
  logic signed [DATA_W-1:0] ga;
  logic signed [DATA_W-1:0] gb;
  logic                     xfer;

  logic                     vld_p1;
  logic [IDW-1:0]           id_p1;
  logic signed [DATA_W-1:0] a_p1;
  logic signed [DATA_W-1:0] b_p1;
  logic signed [PROD_W-1:0] prod;

  // First valid requester at or after p, searching upward with wrap.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [IDW-1:0]   p);
    logic [N_REQ-1:0] g;
    logic             found;
    int               idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && v[idx[IDW-1:0]]) begin
        g[idx[IDW-1:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return g;
  endfunction

  // Grant selection and operand mux for the granted requester.
  always_comb begin
    grant = stall ? '0 : rr_pick(req_valid, ptr);
    gid   = '0;
    ga    = '0;
    gb    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gid = IDW'(i);
        ga  = req_a[DATA_W*i +: DATA_W];
        gb  = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign ptr_next  = (gid == IDW'(N_REQ-1)) ? '0 : gid + IDW'(1);

  // ---- stage p1: accept granted operands ----
  // Control for stage p1 and the round-robin pointer; both freeze under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= xfer;
      if (xfer) ptr <= ptr_next;
    end
  end

  // Operand and tag capture for stage p1; only written on an actual transfer.
  always_ff @(posedge clk) begin
    if (!stall && xfer) begin
      a_p1  <= ga;
      b_p1  <= gb;
      id_p1 <= gid;
    end
  end

  mult_16_basic u_mult (
    .a (a_p1),
    .b (b_p1),
    .p (prod)
  );

  // ---- stage p2: truncated Q15 result to the output ----
  // Output register; result/tag only update when a live entry moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
    end else if (!stall) begin
      rsp_valid <= vld_p1;
      if (vld_p1) begin
        rsp_q  <= fx_slice(prod);
        rsp_id <= id_p1;
      end
    end
  end

  assign busy = vld_p1 | rsp_valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: expected (id, product) pairs are queued
// when a grant is expected and matched by an independent response monitor.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_q;
  logic        busy;

  int checks    = 0;
  int errors    = 0;
  int rsp_count = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] q;
  } exp_t;

  exp_t sbq[$];

  // Per-requester operands and hand-computed truncated Q15 products.
  logic [15:0] opa  [4] = '{16'h2000, 16'h7FFF, 16'h8000, 16'hFFFF};
  logic [15:0] opb  [4] = '{16'h4000, 16'h7FFF, 16'h4000, 16'h7FFF};
  logic [15:0] expq [4] = '{16'h1000, 16'h7FFE, 16'hC000, 16'hFFFF};

  mult_share_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i]       = 1'b1;
    req_a[16*i +: 16]  = a;
    req_b[16*i +: 16]  = b;
  endtask

  task automatic clr_req();
    req_valid = '0;
  endtask

  // One clock cycle: check the grant at mid-cycle and queue the expected response.
  task automatic cyc(input string name, input logic [3:0] exp_rdy,
                     input logic [1:0] id, input logic [15:0] q);
    exp_t e;
    @(negedge clk);
    chk(name, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0) begin
      e.id = id;
      e.q  = q;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 12) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk(name, 32'(sbq.size()), 32'd0);
  endtask

  // Response monitor: a held output under stall is consumed only once.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && !stall) begin
      rsp_count++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d q %0h, expected no response", rsp_id, rsp_q);
      end else begin
        e = sbq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_q",  32'(rsp_q),  32'(e.q));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    stall     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_q",     32'(rsp_q),     32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_ready",     32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 0.5 * 0.5 from requester 0, with latency checked explicitly
    set_req(0, 16'h4000, 16'h4000);
    cyc("t1_grant", 4'b0001, 2'd0, 16'h2000);
    clr_req();
    @(negedge clk);
    chk("t1_lat_t1_valid", 32'(rsp_valid), 32'd0);
    chk("t1_lat_t1_busy",  32'(busy),      32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_lat_t2_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;

    // Requester 2: -0.5 * 0.5, then -1.0 * -1.0 wraps to zero
    set_req(2, 16'hC000, 16'h4000);
    cyc("t2_grant_neg", 4'b0100, 2'd2, 16'hE000);
    set_req(2, 16'h8000, 16'h8000);
    cyc("t2_grant_min", 4'b0100, 2'd2, 16'h0000);
    clr_req();
    drain("t2_drain");

    // Requester 3 alone moves the pointer back to 0
    set_req(3, opa[3], opb[3]);
    cyc("t3_pre", 4'b1000, 2'd3, expq[3]);
    clr_req();
    drain("t3_pre_drain");

    // All requesters continuously valid: strict rotation, one result per cycle
    base = rsp_count;
    for (int i = 0; i < 4; i++) set_req(i, opa[i], opb[i]);
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("t3_grant%0d", k), 4'(1 << (k % 4)), 2'(k % 4), expq[k % 4]);
      if (k >= 1) chk($sformatf("t3_b2b%0d", k), 32'(rsp_valid), 32'd1);
    end
    clr_req();
    drain("t3_drain");
    chk("t3_count", 32'(rsp_count - base), 32'd8);

    // Only 1 and 3 valid with pointer at 2: 3, 1, 3 across the wrap
    set_req(1, opa[1], opb[1]);
    cyc("t4_pre", 4'b0010, 2'd1, expq[1]);
    set_req(3, opa[3], opb[3]);
    cyc("t4_g3a", 4'b1000, 2'd3, expq[3]);
    cyc("t4_g1",  4'b0010, 2'd1, expq[1]);
    cyc("t4_g3b", 4'b1000, 2'd3, expq[3]);
    clr_req();
    drain("t4_drain");

    // Stall with both stages holding entries
    base = rsp_count;
    set_req(0, opa[0], opb[0]);
    cyc("t5_g0", 4'b0001, 2'd0, expq[0]);
    clr_req();
    set_req(1, opa[1], opb[1]);
    cyc("t5_g1", 4'b0010, 2'd1, expq[1]);
    clr_req();
    stall = 1'b1;
    set_req(2, opa[2], opb[2]);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("t5_stall_ready%0d", s), 32'(req_ready), 32'd0);
      chk($sformatf("t5_stall_valid%0d", s), 32'(rsp_valid), 32'd1);
      chk($sformatf("t5_stall_id%0d", s),    32'(rsp_id),    32'd0);
      chk($sformatf("t5_stall_q%0d", s),     32'(rsp_q),     32'(expq[0]));
      chk($sformatf("t5_stall_busy%0d", s),  32'(busy),      32'd1);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    cyc("t5_g2", 4'b0100, 2'd2, expq[2]);
    clr_req();
    drain("t5_drain");
    chk("t5_count", 32'(rsp_count - base), 32'd3);

    // Asynchronous reset with both stages full
    set_req(0, opa[0], opb[0]);
    cyc("t6_g0", 4'b0001, 2'd0, expq[0]);
    clr_req();
    set_req(1, opa[1], opb[1]);
    cyc("t6_g1", 4'b0010, 2'd1, expq[1]);
    clr_req();
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(rsp_valid), 32'd0);
    chk("t6_async_busy",  32'(busy),      32'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = rsp_count;
    @(negedge clk);
    chk("t6_no_stale", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_req(i, opa[i], opb[i]);
    cyc("t6_ptr_zero", 4'b0001, 2'd0, expq[0]);
    clr_req();
    drain("t6_drain");
    chk("t6_count", 32'(rsp_count - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
